// File: rtl/idu32_pkg.sv
// idu32_pkg: shared definitions for the IDU32 decode/issue controller.
//   - RV32 opcode constants used for hazard classification and decoding
//   - one-hot instruction-type bit indices (R I S B U J)
//   - controller state enum
//   - decoded-instruction record and the combinational IDU32 decoder
package idu32_pkg;

    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;
    localparam int ITYPE_W = 6;

    localparam logic [6:0] OP_R_ALU  = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ENV    = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int ITYPE_R = 5;
    localparam int ITYPE_I = 4;
    localparam int ITYPE_S = 3;
    localparam int ITYPE_B = 2;
    localparam int ITYPE_U = 1;
    localparam int ITYPE_J = 0;

    typedef enum logic {
        RUN      = 1'b0,
        ENV_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic               d0en;
        logic               s1en;
        logic               s2en;
        logic [XLEN-1:0]    d0imm;
        logic [XLEN-1:0]    s1;
        logic [XLEN-1:0]    s2imm;
        logic [9:0]         fun;
        logic [ITYPE_W-1:0] itype;
    } dec_t;

    // Hazard classes come straight from the opcode, independent of the
    // decoder enables (ENV is I-type to the decoder but reads nothing here).
    function automatic logic op_uses_rs1(input logic [6:0] op);
        return (op == OP_R_ALU) || (op == OP_I_ALU) || (op == OP_LOAD) ||
               (op == OP_JALR)  || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic op_uses_rs2(input logic [6:0] op);
        return (op == OP_R_ALU) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic op_has_rd(input logic [6:0] op);
        return (op == OP_R_ALU) || (op == OP_I_ALU) || (op == OP_LOAD) ||
               (op == OP_JALR)  || (op == OP_LUI)   || (op == OP_AUIPC) ||
               (op == OP_JAL);
    endfunction

    // IDU32 decoder. d0imm carries rd for writers and the store/branch
    // offset otherwise; s2imm carries rs2 for R/S/B and the immediate for I/U/J.
    function automatic dec_t idu32_decode(input logic [31:0] inst);
        dec_t            d;
        logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [XLEN-1:0] rd_z, rs1_z, rs2_z;
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u = {inst[31:12], 12'b0};
        imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        rd_z  = {27'b0, inst[11:7]};
        rs1_z = {27'b0, inst[19:15]};
        rs2_z = {27'b0, inst[24:20]};
        d = '0;
        case (inst[6:0])
            OP_R_ALU:                          d.itype[ITYPE_R] = 1'b1;
            OP_I_ALU, OP_LOAD, OP_JALR, OP_ENV: d.itype[ITYPE_I] = 1'b1;
            OP_STORE:                          d.itype[ITYPE_S] = 1'b1;
            OP_BRANCH:                         d.itype[ITYPE_B] = 1'b1;
            OP_LUI, OP_AUIPC:                  d.itype[ITYPE_U] = 1'b1;
            OP_JAL:                            d.itype[ITYPE_J] = 1'b1;
            default:                           d.itype = '0;
        endcase
        d.fun  = {inst[14:12], inst[31:25]};
        d.d0en = d.itype[ITYPE_R] | d.itype[ITYPE_I] | d.itype[ITYPE_U] | d.itype[ITYPE_J];
        d.s1en = d.itype[ITYPE_R] | d.itype[ITYPE_I] | d.itype[ITYPE_S] | d.itype[ITYPE_B];
        d.s2en = d.itype[ITYPE_R] | d.itype[ITYPE_S] | d.itype[ITYPE_B];
        if (d.d0en)                  d.d0imm = rd_z;
        else if (d.itype[ITYPE_S])   d.d0imm = imm_s;
        else if (d.itype[ITYPE_B])   d.d0imm = imm_b;
        d.s1 = d.s1en ? rs1_z : '0;
        if (d.s2en)                  d.s2imm = rs2_z;
        else if (d.itype[ITYPE_I])   d.s2imm = imm_i;
        else if (d.itype[ITYPE_U])   d.s2imm = imm_u;
        else if (d.itype[ITYPE_J])   d.s2imm = imm_j;
        return d;
    endfunction

endpackage

// File: rtl/idu32_scoreboard.sv
// idu32_scoreboard: 32-entry busy-bit register scoreboard.
// Optional macro: IDU_ISSUE_WB_BYPASS_EN -- the retiring register is seen as
// free on the read ports and for env_clear in the writeback cycle itself.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   set_en, set_rd        mark a register busy (issue of a writer)
//   clr_en, clr_rd        retire a register (writeback)
//   rs1, rs2, rd          read addresses
//   rs1_busy, rs2_busy, rd_busy   busy flags for the read addresses
//   env_clear             no register busy as seen by the hazard logic
//   empty                 registered busy vector is all zero
module idu32_scoreboard
    import idu32_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic [4:0] set_rd,
    input  logic       clr_en,
    input  logic [4:0] clr_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy,
    output logic       env_clear,
    output logic       empty
);

    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] clr_mask;
    logic [REG_NUM-1:0] byp_mask;
    logic [REG_NUM-1:0] view;

    // Bit 0 is masked out of both masks so x0 can never become busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_rd] = 1'b1;
        if (clr_en) clr_mask[clr_rd] = 1'b1;
        set_mask[0] = 1'b0;
        clr_mask[0] = 1'b0;
    end

    // Set is ORed after the clear: a new producer issuing in the same cycle
    // an older write retires keeps the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= (busy & ~clr_mask) | set_mask;
    end

`ifdef IDU_ISSUE_WB_BYPASS_EN
    assign byp_mask = clr_mask;
`else
    assign byp_mask = '0;
`endif

    assign view      = busy & ~byp_mask;
    assign rs1_busy  = view[rs1];
    assign rs2_busy  = view[rs2];
    assign rd_busy   = view[rd];
    assign env_clear = (view == '0);
    assign empty     = (busy == '0);

endmodule

// File: rtl/idu32_issue_ctrl.sv
// idu32_issue_ctrl: RV32 decode/issue controller between IFU and EXU.
// Holds one instruction in decode register D, decodes it with IDU32, checks
// RAW/WAW hazards against the scoreboard and moves it to issue register E.
// ENV instructions issue only with an empty scoreboard and block fetch until
// env_done.
// Optional macro: IDU_ISSUE_WB_BYPASS_EN (writeback bypass into hazard check).
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   if_valid/if_ready/if_inst/if_pc   fetch handshake and payload
//   ex_valid/ex_ready                 issue handshake
//   ex_pc, ex_d0en, ex_s1en, ex_s2en, ex_d0imm, ex_s1, ex_s2imm,
//   ex_fun, ex_itype                  registered decoder outputs
//   wb_valid, wb_rd                   register retirement
//   flush                             kill D and E, return to RUN
//   env_done                          EXU completed the ENV instruction
//   sb_empty                          no register busy
//
// state    | meaning
// RUN      | normal fetch/issue
// ENV_WAIT | ENV issued, fetch blocked until env_done or flush
module idu32_issue_ctrl
    import idu32_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int INST_MAX = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [INST_MAX-1:0] if_inst,
    input  logic [WIDTH-1:0]    if_pc,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [WIDTH-1:0]    ex_pc,
    output logic                ex_d0en,
    output logic                ex_s1en,
    output logic                ex_s2en,
    output logic [WIDTH-1:0]    ex_d0imm,
    output logic [WIDTH-1:0]    ex_s1,
    output logic [WIDTH-1:0]    ex_s2imm,
    output logic [9:0]          ex_fun,
    output logic [5:0]          ex_itype,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic                flush,
    input  logic                env_done,
    output logic                sb_empty
);

    state_t              state, state_nx;
    logic                run_mode;
    logic                d_valid;
    logic [INST_MAX-1:0] d_inst;
    logic [WIDTH-1:0]    d_pc;
    dec_t                dec;
    logic [6:0]          opcode;
    logic [4:0]          rs1, rs2, rd;
    logic                uses_rs1, uses_rs2, writes_rd, is_env;
    logic                rs1_busy, rs2_busy, rd_busy, env_clear;
    logic                hazard, env_ok, issue, fetch;

    assign dec       = idu32_decode(d_inst[31:0]);
    assign opcode    = d_inst[6:0];
    assign rd        = d_inst[11:7];
    assign rs1       = d_inst[19:15];
    assign rs2       = d_inst[24:20];
    assign uses_rs1  = op_uses_rs1(opcode);
    assign uses_rs2  = op_uses_rs2(opcode);
    assign writes_rd = op_has_rd(opcode) && (rd != 5'd0);
    assign is_env    = (opcode == OP_ENV);

    idu32_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (issue & writes_rd),
        .set_rd    (rd),
        .clr_en    (wb_valid),
        .clr_rd    (wb_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rd_busy   (rd_busy),
        .env_clear (env_clear),
        .empty     (sb_empty)
    );

    assign hazard = (uses_rs1 & rs1_busy) | (uses_rs2 & rs2_busy) | (writes_rd & rd_busy);
    assign env_ok = ~is_env | env_clear;
    assign issue  = d_valid & ~hazard & env_ok & (~ex_valid | ex_ready) & ~flush;
    assign fetch  = if_valid & if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:      if (issue && is_env)     state_nx = ENV_WAIT;
            ENV_WAIT: if (env_done || flush)   state_nx = RUN;
            default:                           state_nx = RUN;
        endcase
    end

    always_comb begin
        run_mode = (state == RUN);
        if_ready = run_mode & ~flush & (~d_valid | issue);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_inst  <= '0;
            d_pc    <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (fetch) begin
            d_valid <= 1'b1;
            d_inst  <= if_inst;
            d_pc    <= if_pc;
        end else if (issue) begin
            d_valid <= 1'b0;
        end
    end

    // Fields only load on issue, so they hold while ex_valid & ~ex_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_d0en  <= 1'b0;
            ex_s1en  <= 1'b0;
            ex_s2en  <= 1'b0;
            ex_d0imm <= '0;
            ex_s1    <= '0;
            ex_s2imm <= '0;
            ex_fun   <= '0;
            ex_itype <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (issue) begin
            ex_valid <= 1'b1;
            ex_pc    <= d_pc;
            ex_d0en  <= dec.d0en;
            ex_s1en  <= dec.s1en;
            ex_s2en  <= dec.s2en;
            ex_d0imm <= WIDTH'(dec.d0imm);
            ex_s1    <= WIDTH'(dec.s1);
            ex_s2imm <= WIDTH'(dec.s2imm);
            ex_fun   <= dec.fun;
            ex_itype <= dec.itype;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: doc/idu32_issue_ctrl.md
# idu32_issue_ctrl

Decode/issue controller for the RV32 decode stage. It holds one fetched instruction in a decode register and runs it through the IDU32 decoder. A 32-entry busy-bit scoreboard detects RAW and WAW hazards, and hazard-free instructions move into an issue register toward the execute unit under valid/ready handshakes. It sits between the IFU and EXU, serialises environment-call instructions and clears pending registers on writeback.

## Interface
Parameters:
- `WIDTH`, 32, datapath width of PC and decoded fields.
- `INST_MAX`, 32, instruction width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_valid`  in  1  fetch has an instruction.
- `if_ready`  out  1  decode register can accept.
- `if_inst`  in  INST_MAX  instruction word.
- `if_pc`  in  WIDTH  instruction PC.
- `ex_valid`  out  1  issue register holds an instruction.
- `ex_ready`  in  1  EXU accepts.
- `ex_pc`  out  WIDTH  issued PC.
- `ex_d0en`, `ex_s1en`, `ex_s2en`  out  1 each  registered decoder enables.
- `ex_d0imm`, `ex_s1`, `ex_s2imm`  out  WIDTH each  registered decoder fields.
- `ex_fun`  out  10  registered {funct3, funct7}.
- `ex_itype`  out  6  registered one-hot type, R I S B U J.
- `wb_valid`  in  1  writeback retires a register write.
- `wb_rd`  in  5  register being retired.
- `flush`  in  1  redirect; kill unissued work.
- `env_done`  in  1  single-cycle pulse when the EXU completes an ENV instruction.
- `sb_empty`  out  1  no register busy.

## Operation
- Decode register D holds `d_valid`, `d_inst` and `d_pc`. Fetch fires when `if_valid & if_ready`.
- `if_ready = state==RUN & ~flush & (~d_valid | issue)`. Throughput is one instruction per cycle.
- Source and destination classes are computed locally from `d_inst[6:0]`. The decoder enables are only forwarded, never used for hazards.
  - `uses_rs1`: opcode in {R, I-ALU, LOAD, JALR, S, B}.
  - `uses_rs2`: opcode in {R, S, B}.
  - `writes_rd`: opcode in {R, I-ALU, LOAD, JALR, LUI, AUIPC, JAL} and rd != 0.
- Hazard conditions:
  - RAW: `uses_rs1 & busy[rs1]`, or `uses_rs2 & busy[rs2]`.
  - WAW: `writes_rd & busy[rd]`.
  - Register x0 is never busy.
- ENV instruction (opcode 1110011) issues only when `busy == 0`.
- Issue condition: `issue = d_valid & ~hazard & env_ok & (~ex_valid | ex_ready) & ~flush`.
- On issue, the issue register E loads the decoder outputs and `ex_pc`, and sets `busy[rd]` if `writes_rd`.
- If E empties without a new issue (`ex_valid & ex_ready & ~issue`), `ex_valid` goes to 0.
- `wb_valid` clears `busy[wb_rd]`. Clearing with `wb_rd == 0` has no effect.
- Same-cycle set and clear of the same bit: the set wins, because the new producer is in flight.
- State machine:
  - RUN → ENV_WAIT when an ENV instruction issues.
  - ENV_WAIT → RUN on `env_done` or `flush`.
  - Fetch is blocked in ENV_WAIT.
- `flush` clears `d_valid` and `ex_valid` at the next edge and forces RUN.
  - It blocks fetch and issue in the flush cycle.
  - The scoreboard is not cleared, because in-flight writebacks still arrive.
- `sb_empty = (busy == 0)`. It is registered state, not bypassed.
- Unknown opcode: passes through with no rs/rd tracking.

## Timing
- Reset (`rst_n` low, asynchronous) values:
  - `d_valid = 0`, `ex_valid = 0`.
  - All `ex_*` data outputs = 0.
  - `busy = 0`, `state = RUN`.
  - So `if_ready = 1` and `sb_empty = 1`.
- Reset mid-operation discards D, E and the scoreboard immediately.
- Latency: fetch fire at edge t, then issue at edge t+1 when hazard-free, so `ex_valid` is high in cycle t+1. Minimum latency is 1 cycle from D to E.
- `ex_*` fields are stable while `ex_valid & ~ex_ready`.
- `if_ready` and the hazard logic are combinational from state, `ex_ready` and `flush`, plus the `wb_*` inputs when the bypass is enabled.
- Minimum ENV round-trip: issue at edge t, `env_done` in cycle ≥ t+1, fetch resumes in the cycle after `env_done`.

## Configuration
- `IDU_ISSUE_WB_BYPASS_EN` defined:
  - A `wb_valid` whose `wb_rd` matches a hazard source masks that hazard in the same cycle, so the instruction issues in the writeback cycle.
  - `env_ok` also treats the retiring bit as clear.
- Not defined: the hazard check sees only registered `busy`. Issue happens one cycle after the writeback.

## Structure
- Package `idu32_pkg`:
  - Opcode constants: R_ALU, I_ALU, LOAD, JALR, ENV, STORE, BRANCH, LUI, AUIPC, JAL.
  - itype bit indices.
  - State enum {RUN, ENV_WAIT}.
- Sub-module `idu32_scoreboard`:
  - 32 busy bits with set, clear and priority logic.
  - Read ports for rs1, rs2 and rd, with the optional bypass.
  - `empty` output.
- IDU32 is instantiated combinationally on `d_inst`.

## Test plan
- Back-to-back independent instructions `addi x1,x0,1` then `addi x2,x0,2` with `ex_ready=1` → `ex_valid` high in two consecutive cycles, `if_ready` stays 1, `busy[1]` and `busy[2]` set.
- RAW `addi x5,x0,1` then `add x6,x5,x5`, with `wb_rd=5` pulsed 3 cycles later → `add` issues in the wb cycle with the bypass, one cycle later without it. The hold time is checked against the macro.
- `sw x3,0(x4)` with x4 busy → stalls, `if_ready=0` while D is full. `busy` is not modified by the store (no rd tracking).
- `ecall` with `busy[7]` set → stalls until `wb_rd=7`, then issues. State is ENV_WAIT with `if_ready=0` until `env_done`, then fetch resumes.
- `flush` while D and E are both full and `ex_ready=0` → next cycle `ex_valid=0`, `d_valid=0`, `busy` unchanged, `if_ready=1`.
- Assert `rst_n` low mid-stall → `ex_valid=0`, `sb_empty=1`, all `ex_*`=0 immediately without a clock edge.
